// File: rtl/rs_exec_unit.sv
// ---------------------------------------------------------------------------
// rs_exec_unit
//   Reservation-station execution unit. DEPTH tagged entries take dispatched
//   integer ops whose operands are either valued or pending on a producer tag.
//   Pending operands are woken by snooping the CDB. The lowest-index ready
//   entry issues into a LAT-cycle pipeline, and the result is offered to the
//   CDB arbiter over a valid/ready handshake. An entry is released only when
//   its own tag is seen on the CDB, so its tag cannot be reused too early.
//
// Ports
//   CLOCK_50, RSTN_N              clock (rising edge), async active-low reset
//   disp_valid / disp_ready       dispatch handshake
//   disp_tag                      tag the next dispatch will take (0 = full)
//   disp_op                       00 ADD, 01 SUB, 10 SLT, 11 SLTU
//   disp_val1/2, disp_tag1/2      operand values / producer tags (0 = valued)
//   cdb_valid, cdb_tag, cdb_data  common data bus snoop
//   res_valid/res_ready           result handshake to the CDB arbiter
//   res_tag, res_data             producing entry tag and result value
// ---------------------------------------------------------------------------
module rs_exec_unit #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 2,
    parameter int DEPTH    = 3,
    parameter int TAG_BASE = 1,
    parameter int LAT      = 2
) (
    input  logic             CLOCK_50,
    input  logic             RSTN_N,
    input  logic             disp_valid,
    output logic             disp_ready,
    output logic [TAG_W-1:0] disp_tag,
    input  logic [1:0]       disp_op,
    input  logic [XLEN-1:0]  disp_val1,
    input  logic [XLEN-1:0]  disp_val2,
    input  logic [TAG_W-1:0] disp_tag1,
    input  logic [TAG_W-1:0] disp_tag2,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic [XLEN-1:0]  res_data,
    input  logic             res_ready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        E_FREE   = 2'd0,
        E_WAIT   = 2'd1,
        E_ISSUED = 2'd2
    } ent_state_t;

    function automatic logic [TAG_W-1:0] own_tag(input int idx);
        return TAG_W'(TAG_BASE + idx);
    endfunction

    ent_state_t       ent_st [DEPTH];
    logic [1:0]       ent_op [DEPTH];
    logic [XLEN-1:0]  ent_v1 [DEPTH];
    logic [XLEN-1:0]  ent_v2 [DEPTH];
    logic [TAG_W-1:0] ent_t1 [DEPTH];
    logic [TAG_W-1:0] ent_t2 [DEPTH];

    logic             pv    [LAT];
    logic [TAG_W-1:0] ptag  [LAT];
    logic [XLEN-1:0]  pdata [LAT];

    logic             alloc_hit;
    logic [IDX_W-1:0] alloc_idx;
    logic             iss_hit;
    logic [IDX_W-1:0] iss_idx;
    logic             disp_fire;
    logic             advance;
    logic             do_issue;
    logic             cdb_hit;
    logic             byp1;
    logic             byp2;
    logic [XLEN-1:0]  cap_v1;
    logic [XLEN-1:0]  cap_v2;
    logic [TAG_W-1:0] cap_t1;
    logic [TAG_W-1:0] cap_t2;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [XLEN-1:0]  alu_out;

    // Allocation and issue selection look only at registered state, so an
    // entry freed or woken at an edge is not visible until the next cycle.
    always_comb begin
        alloc_hit = 1'b0;
        alloc_idx = '0;
        iss_hit   = 1'b0;
        iss_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_st[i] == E_FREE) begin
                alloc_hit = 1'b1;
                alloc_idx = IDX_W'(i);
            end
            if (ent_st[i] == E_WAIT && ent_t1[i] == '0 && ent_t2[i] == '0) begin
                iss_hit = 1'b1;
                iss_idx = IDX_W'(i);
            end
        end
    end

    assign disp_ready = alloc_hit;
    assign disp_tag   = alloc_hit ? own_tag(int'(alloc_idx)) : '0;
    assign disp_fire  = disp_valid && alloc_hit;

    // The whole pipeline freezes while a result is offered but not taken.
    assign advance  = !(res_valid && !res_ready);
    assign do_issue = iss_hit && advance;

    assign cdb_hit = cdb_valid && (cdb_tag != '0);

    // A producer broadcasting in the dispatch cycle is captured directly.
    always_comb begin
        byp1   = cdb_hit && (disp_tag1 == cdb_tag);
        byp2   = cdb_hit && (disp_tag2 == cdb_tag);
        cap_v1 = byp1 ? cdb_data : disp_val1;
        cap_v2 = byp2 ? cdb_data : disp_val2;
        cap_t1 = byp1 ? '0 : disp_tag1;
        cap_t2 = byp2 ? '0 : disp_tag2;
    end

    always_comb begin
        op_a = ent_v1[iss_idx];
        op_b = ent_v2[iss_idx];
        case (ent_op[iss_idx])
            2'b00:   alu_out = op_a + op_b;
            2'b01:   alu_out = op_a - op_b;
            2'b10:   alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
        if (!RSTN_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_st[i] <= E_FREE;
                ent_op[i] <= '0;
                ent_v1[i] <= '0;
                ent_v2[i] <= '0;
                ent_t1[i] <= '0;
                ent_t2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                case (ent_st[i])
                    E_FREE: begin
                        if (disp_fire && alloc_idx == IDX_W'(i)) begin
                            ent_st[i] <= E_WAIT;
                            ent_op[i] <= disp_op;
                            ent_v1[i] <= cap_v1;
                            ent_v2[i] <= cap_v2;
                            ent_t1[i] <= cap_t1;
                            ent_t2[i] <= cap_t2;
                        end
                    end
                    E_WAIT: begin
                        if (cdb_hit && ent_t1[i] == cdb_tag) begin
                            ent_v1[i] <= cdb_data;
                            ent_t1[i] <= '0;
                        end
                        if (cdb_hit && ent_t2[i] == cdb_tag) begin
                            ent_v2[i] <= cdb_data;
                            ent_t2[i] <= '0;
                        end
                        if (do_issue && iss_idx == IDX_W'(i)) begin
                            ent_st[i] <= E_ISSUED;
                        end
                    end
                    E_ISSUED: begin
                        if (cdb_hit && cdb_tag == own_tag(i)) begin
                            ent_st[i] <= E_FREE;
                        end
                    end
                    default: ent_st[i] <= E_FREE;
                endcase
            end
        end
    end

    // Stage 0 loads at the issue edge; res_* is the stage after LAT-1, so a
    // result appears LAT edges after issue.
    always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
        if (!RSTN_N) begin
            for (int j = 0; j < LAT; j++) begin
                pv[j]    <= 1'b0;
                ptag[j]  <= '0;
                pdata[j] <= '0;
            end
            res_valid <= 1'b0;
            res_tag   <= '0;
            res_data  <= '0;
        end else if (advance) begin
            pv[0]    <= do_issue;
            ptag[0]  <= own_tag(int'(iss_idx));
            pdata[0] <= alu_out;
            for (int j = 1; j < LAT; j++) begin
                pv[j]    <= pv[j-1];
                ptag[j]  <= ptag[j-1];
                pdata[j] <= pdata[j-1];
            end
            res_valid <= pv[LAT-1];
            res_tag   <= ptag[LAT-1];
            res_data  <= pdata[LAT-1];
        end
    end

endmodule

// File: tb/tb_rs_exec_unit.sv
module tb_rs_exec_unit;

    logic        CLOCK_50;
    logic        RSTN_N;
    logic        disp_valid;
    logic        disp_ready;
    logic [1:0]  disp_tag;
    logic [1:0]  disp_op;
    logic [31:0] disp_val1;
    logic [31:0] disp_val2;
    logic [1:0]  disp_tag1;
    logic [1:0]  disp_tag2;
    logic        cdb_valid;
    logic [1:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        res_valid;
    logic [1:0]  res_tag;
    logic [31:0] res_data;
    logic        res_ready;

    int checks = 0;
    int errors = 0;

    logic [33:0] sb [$];

    rs_exec_unit dut (
        .CLOCK_50   (CLOCK_50),
        .RSTN_N     (RSTN_N),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_tag   (disp_tag),
        .disp_op    (disp_op),
        .disp_val1  (disp_val1),
        .disp_val2  (disp_val2),
        .disp_tag1  (disp_tag1),
        .disp_tag2  (disp_tag2),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .res_valid  (res_valid),
        .res_tag    (res_tag),
        .res_data   (res_data),
        .res_ready  (res_ready)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic dispatch(input logic [1:0] op, input logic [31:0] v1, input logic [1:0] t1,
                            input logic [31:0] v2, input logic [1:0] t2);
        disp_op    = op;
        disp_val1  = v1;
        disp_tag1  = t1;
        disp_val2  = v2;
        disp_tag2  = t2;
        disp_valid = 1'b1;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic cdb_bcast(input logic [1:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
        tick();
        cdb_valid = 1'b0;
    endtask

    // Called one cycle after the enabling edge (dispatch or wake): issue at
    // the next edge, result LAT=2 edges later, then one edge to consume it.
    task automatic lat_check(input string name);
        tick();
        chk({name, "_lat1"}, 64'(res_valid), 64'd0);
        tick();
        chk({name, "_lat2"}, 64'(res_valid), 64'd0);
        tick();
        chk({name, "_lat3"}, 64'(res_valid), 64'd1);
        tick();
    endtask

    // Scoreboard: every accepted result is compared with the oldest expectation.
    always @(negedge CLOCK_50) begin
        if (RSTN_N && res_valid && res_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed_tag=%0h observed_data=%0h expected=none", res_tag, res_data);
            end
            if (sb.size() != 0) begin
                checks++;
                assert ({res_tag, res_data} === sb[0]) else begin
                    errors++;
                    $error("FAIL sb_result observed=%0h expected=%0h", {res_tag, res_data}, sb[0]);
                end
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN_N     = 1'b0;
        disp_valid = 1'b0;
        disp_op    = 2'b00;
        disp_val1  = '0;
        disp_val2  = '0;
        disp_tag1  = '0;
        disp_tag2  = '0;
        cdb_valid  = 1'b0;
        cdb_tag    = '0;
        cdb_data   = '0;
        res_ready  = 1'b1;
        #25 RSTN_N = 1'b1;
        tick();

        chk("rst_disp_ready", 64'(disp_ready), 64'd1);
        chk("rst_disp_tag",   64'(disp_tag),   64'd1);
        chk("rst_res_valid",  64'(res_valid),  64'd0);
        chk("rst_res_tag",    64'(res_tag),    64'd0);
        chk("rst_res_data",   64'(res_data),   64'd0);

        // ADD 5+7, all operands valued
        sb.push_back({2'd1, 32'd12});
        dispatch(2'b00, 32'd5, 2'd0, 32'd7, 2'd0);
        lat_check("add");
        cdb_bcast(2'd1, 32'd12);

        // SUB with operand 1 pending on tag 3
        sb.push_back({2'd1, 32'hFFFF_FFFA});
        dispatch(2'b01, 32'd0, 2'd3, 32'd10, 2'd0);
        chk("sub_disp_tag", 64'(disp_tag), 64'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sub_no_early_issue", 64'(res_valid), 64'd0);
        end
        cdb_bcast(2'd3, 32'd4);
        lat_check("sub");
        cdb_bcast(2'd1, 32'hFFFF_FFFA);

        // dispatch-cycle bypass on operand 2
        sb.push_back({2'd1, 32'd10});
        disp_op    = 2'b00;
        disp_val1  = 32'd1;
        disp_tag1  = 2'd0;
        disp_val2  = 32'd0;
        disp_tag2  = 2'd2;
        disp_valid = 1'b1;
        cdb_valid  = 1'b1;
        cdb_tag    = 2'd2;
        cdb_data   = 32'd9;
        tick();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        lat_check("bypass");
        cdb_bcast(2'd1, 32'd10);

        // fill: entry 0 ready, entries 1 and 2 depend on entry 0's result
        sb.push_back({2'd1, 32'd5});
        dispatch(2'b00, 32'd2, 2'd0, 32'd3, 2'd0);
        chk("fill_tag1", 64'(disp_tag), 64'd2);
        sb.push_back({2'd2, 32'd15});
        dispatch(2'b00, 32'd0, 2'd1, 32'd10, 2'd0);
        chk("fill_tag2", 64'(disp_tag), 64'd3);
        sb.push_back({2'd3, 32'd0});
        dispatch(2'b01, 32'd0, 2'd1, 32'd0, 2'd1);
        chk("full_disp_ready", 64'(disp_ready), 64'd0);
        chk("full_disp_tag",   64'(disp_tag),   64'd0);
        dispatch(2'b00, 32'd7, 2'd0, 32'd8, 2'd0);
        chk("full_ignored_ready", 64'(disp_ready), 64'd0);
        chk("full_res_valid", 64'(res_valid), 64'd1);
        cdb_valid = 1'b1;
        cdb_tag   = 2'd1;
        cdb_data  = 32'd5;
        #1;
        chk("free_same_cycle", 64'(disp_ready), 64'd0);
        tick();
        cdb_valid = 1'b0;
        chk("free_next_ready", 64'(disp_ready), 64'd1);
        chk("free_next_tag",   64'(disp_tag),   64'd1);
        for (int i = 0; i < 6; i++) tick();
        chk("fill_drained", 64'(res_valid), 64'd0);
        cdb_bcast(2'd2, 32'd15);
        cdb_bcast(2'd3, 32'd0);

        // compares, with a 3-cycle stall on the output
        res_ready = 1'b0;
        sb.push_back({2'd1, 32'd1});
        dispatch(2'b10, 32'hFFFF_FFFF, 2'd0, 32'd1, 2'd0);
        sb.push_back({2'd2, 32'd0});
        dispatch(2'b11, 32'hFFFF_FFFF, 2'd0, 32'd1, 2'd0);
        sb.push_back({2'd3, 32'd101});
        dispatch(2'b00, 32'd100, 2'd0, 32'd1, 2'd0);
        tick();
        chk("stall_valid0", 64'(res_valid), 64'd1);
        chk("stall_tag0",   64'(res_tag),   64'd1);
        chk("stall_data0",  64'(res_data),  64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 64'(res_valid), 64'd1);
            chk("stall_tag",   64'(res_tag),   64'd1);
            chk("stall_data",  64'(res_data),  64'd1);
        end
        res_ready = 1'b1;
        tick();
        chk("b2b_valid1", 64'(res_valid), 64'd1);
        chk("b2b_tag1",   64'(res_tag),   64'd2);
        tick();
        chk("b2b_valid2", 64'(res_valid), 64'd1);
        chk("b2b_tag2",   64'(res_tag),   64'd3);
        tick();
        chk("b2b_empty",  64'(res_valid), 64'd0);
        cdb_bcast(2'd1, 32'd1);
        cdb_bcast(2'd2, 32'd0);
        cdb_bcast(2'd3, 32'd101);

        // reset with two ops in flight
        sb.push_back({2'd1, 32'd2});
        dispatch(2'b00, 32'd1, 2'd0, 32'd1, 2'd0);
        sb.push_back({2'd2, 32'd4});
        dispatch(2'b00, 32'd2, 2'd0, 32'd2, 2'd0);
        tick();
        tick();
        chk("inflight_valid", 64'(res_valid), 64'd1);
        RSTN_N = 1'b0;
        #1;
        chk("async_rst_valid", 64'(res_valid), 64'd0);
        sb.delete();
        #5 RSTN_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_no_result", 64'(res_valid), 64'd0);
        end
        chk("post_rst_disp_tag", 64'(disp_tag), 64'd1);
        sb.push_back({2'd1, 32'd7});
        dispatch(2'b00, 32'd3, 2'd0, 32'd4, 2'd0);
        chk("post_rst_next_tag", 64'(disp_tag), 64'd2);
        lat_check("post_rst");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_exec_unit.md
Name: rs_exec_unit

Overview:
Parametrised reservation-station execution unit, successor to the single-entry fixed-delay adder slots. Holds DEPTH tagged entries that accept dispatched operations with operands either valued or pending on a producer tag. Snoops the common data bus (CDB) to wake pending operands. Issues ready entries into a LAT-stage integer pipeline and offers results to the CDB arbiter through a valid/ready handshake.

Parameters:
XLEN, 32, operand/result width
TAG_W, 2, tag width; tag value 0 means "operand valid, no producer"
DEPTH, 3, number of entries (1..2^TAG_W-1)
TAG_BASE, 1, tag of entry 0; entry i owns tag TAG_BASE+i (must be nonzero, must fit TAG_W)
LAT, 2, execute latency in cycles (>=1)

Ports:
CLOCK_50  in  1  clock, rising edge
RSTN_N  in  1  asynchronous active-low reset
disp_valid  in  1  dispatch request
disp_ready  out  1  at least one entry FREE
disp_tag  out  TAG_W  tag of the entry the next dispatch takes (lowest-index FREE); 0 when none
disp_op  in  2  00 ADD, 01 SUB, 10 SLT, 11 SLTU
disp_val1 / disp_val2  in  XLEN  operand values (used when matching tag is 0)
disp_tag1 / disp_tag2  in  TAG_W  producer tags of operands
cdb_valid  in  1  broadcast valid
cdb_tag  in  TAG_W  broadcast producer tag
cdb_data  in  XLEN  broadcast value
res_valid  out  1  result offered
res_tag  out  TAG_W  tag of producing entry
res_data  out  XLEN  result
res_ready  in  1  arbiter accepts result

Behaviour:
- Reset (async, RSTN_N low): all entries FREE, operand tags 0, pipeline empty, res_valid 0, res_tag 0, res_data 0. disp_ready is 1 after reset. Reset mid-operation discards all entries and in-flight results. No CDB output is produced for them.
- Entry states: FREE -> WAIT -> ISSUED -> FREE.
  - FREE->WAIT on the dispatch fire (disp_valid && disp_ready) into the lowest-index FREE entry. Operands and tags are captured.
  - WAIT->ISSUED when selected for issue.
  - ISSUED->FREE when cdb_valid && cdb_tag == own tag. Tag reuse is safe only after the broadcast is seen.
- Dispatch bypass: if cdb_valid and cdb_tag == disp_tagN (nonzero) in the dispatch cycle, the entry captures cdb_data and stores tag 0.
- Wake-up: in any WAIT entry, an operand tag matching a valid nonzero cdb_tag takes cdb_data and its tag becomes 0 at that edge. Both operands may wake in the same cycle.
- Issue: an entry is ready when it is WAIT and both tags are 0. The lowest-index ready entry issues, one per cycle, only when the pipeline is not stalled. An entry woken at edge k is issuable in cycle k+1; there is no same-cycle wake-and-issue.
- Pipeline: an op issued at edge k drives res_valid=1 from edge k+LAT when there is no stall.
  - Stall condition: res_valid && !res_ready. All stages freeze and no issue occurs.
  - Result fire: res_valid && res_ready. The next stage loads the same edge, giving full throughput of 1 result per cycle.
- Arithmetic, mod 2^XLEN:
  - ADD: a+b
  - SUB: a-b
  - SLT: signed a<b gives 1, else 0 (zero-extended)
  - SLTU: unsigned compare
- res_data and res_tag are held stable while res_valid && !res_ready.
- Full: disp_ready=0 and disp_tag=0. A disp_valid while full is ignored with no state change.
- Simultaneous events:
  - Dispatch, wake-up, issue, result fire and entry free may all occur in one cycle.
  - An entry freed by the CDB at edge k is not allocatable until cycle k+1; disp_tag is computed from registered state.
- cdb_tag 0 with cdb_valid is ignored.

Test Plan:
- Reset, then dispatch ADD val1=5 val2=7 with tags 0 (LAT=2) -> disp_tag=1. Issue next cycle. res_valid 2 cycles after issue with res_tag=1, res_data=12.
- Dispatch SUB with tag1=3, val2=10, then CDB tag3 data=4 -> no issue before wake. Then res_data=0xFFFFFFFA, res_tag of that entry.
- Dispatch with disp_tag2 == cdb_tag in the same cycle (cdb_data=9, val1=1, ADD) -> bypass captured, result 10 with no extra wait.
- Fill all 3 entries with pending tags -> disp_ready=0, disp_tag=0, and a 4th disp_valid is ignored. CDB tag of entry 1 -> freed, and disp_ready=1 the next cycle.
- SLT 0xFFFFFFFF vs 1 -> 1. SLTU same operands -> 0. Hold res_ready=0 for 3 cycles -> res_data/res_tag stable and no new issue. Release -> back-to-back results, 1 per cycle.
- Assert RSTN_N low while two ops are in flight -> res_valid falls immediately (async). After release, all entries are FREE and no stale result appears.
